uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Memory-mapped UART transmitter peripheral that sits directly downstream of MIO_BUS, alongside SPIO and Multi_8CH32.
- The bus address decode produces a write strobe (uart_we) and delivers the low byte of Peripheral_in as wr_data.
- Bytes are buffered in a FIFO and serialised 8N1, LSB first, on txd.
- A status word is returned to the bus read mux; irq feeds the CPU INT input.

Parameters:
CLK_DIV, 434, clk cycles per bit (100 MHz / 434 ≈ 230400 baud); legal range >= 2
FIFO_AW, 4, log2 of FIFO depth (depth = 16)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
uart_we  input  1  one-cycle write strobe from bus decode
wr_data  input  8  byte to enqueue, sampled when uart_we=1
clr_ovf  input  1  one-cycle pulse; clears the overflow flag
txd  output  1  serial line, idles high
status  output  32  {23'b0, count[FIFO_AW:0], ovf, empty, full, busy}; width shown for FIFO_AW=4
irq  output  1  level; 1 when the FIFO is empty and the FSM is idle (TX done)

Behaviour:
Reset
- rst=1 asynchronously forces: txd=1, FIFO pointers=0, count=0, ovf=0, state=IDLE, baud counter=0.
- Resulting outputs: busy=0, full=0, empty=1, irq=1.
- Reset mid-frame aborts the frame immediately; txd returns high with no glitch low.

FIFO
- Circular buffer, depth 2^FIFO_AW; FIFO_AW+1-bit count.
- A write is accepted when uart_we=1 and (count < depth, or a pop occurs in the same cycle).
- A write that is not accepted is dropped and sets ovf=1.
- ovf stays set until clr_ovf=1. If clr_ovf and an overflowing write occur in the same cycle, ovf ends at 1.
- Simultaneous accepted push and pop leaves count unchanged; both pointers advance modulo depth.
- full = (count == depth). empty = (count == 0). Both are derived from the registered count.

FSM (states IDLE, START, DATA, STOP)
- baud_cnt counts 0..CLK_DIV-1; bit_end = (baud_cnt == CLK_DIV-1).
- IDLE: txd=1. If count != 0: pop, load shift register, baud_cnt=0, txd=0, go to START (all on the same edge).
- START: hold txd=0. At bit_end, drive txd=shift[0], bit index=0, go to DATA.
- DATA: at bit_end, shift right and increment the bit index. After bit 7 ends, txd=1 and go to STOP.
- STOP: txd=1 for CLK_DIV cycles. At bit_end:
  - if count != 0, pop and go directly to START with txd=0 (no idle gap);
  - else go to IDLE.
- busy = (state != IDLE).
- txd is driven from a register only (glitch-free).

Timing
- Latency: uart_we at edge N into an empty, idle block gives count=1 after N, then pop and txd=0 after edge N+1.
- Frame length is exactly 10*CLK_DIV cycles.
- Back-to-back frames are contiguous.

Optional Feature:
UART_PARITY_EN
- Defined: adds state PARITY between DATA and STOP. It transmits the even-parity bit (XOR of the 8 data bits) for CLK_DIV cycles, so the frame becomes 11*CLK_DIV cycles. Bit 4 of status becomes the parity bit of the last popped byte, and count shifts to bits [FIFO_AW+5:5].
- Not defined: 8N1 as described above, 10-bit frames, status layout as listed in Ports.

Test Plan (bench uses CLK_DIV=4, FIFO_AW=4):
1. Reset release, no writes -> txd=1, status=32'h0000_0004, irq=1, held for 100 cycles.
2. Write 0x55 once -> txd=0 two edges after the strobe; then 1,0,1,0,1,0,1,0, then stop 1, each bit exactly 4 cycles (40-cycle frame); busy=1 throughout; irq returns to 1 at frame end.
3. Write 0xA3 then 0x0F on consecutive cycles -> two contiguous frames: bits 0,1,1,0,0,0,1,0,1,1 then 0,1,1,1,1,0,0,0,0,1; no idle gap; total 80 cycles.
4. While the FSM is busy, write 17 bytes 0x00..0x10 -> 16 accepted after one pop frees space per the accept rule; the final dropped write sets ovf=1 (status bit3). clr_ovf pulse -> bit3=0. A write when count<16 is accepted.
5. Assert rst during DATA bit 3 of a 0x00 frame -> txd=1 immediately (before the next clk edge), count=0; after release, no further frames are sent.
6. FIFO full and a pop coinciding with a write on the STOP->START edge -> write accepted, count stays 16, ovf=0.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: bus-attached UART transmitter with a byte FIFO.
// Bytes written via uart_we are queued and sent 8N1, LSB first, on txd.
// Frames are sent back to back while data is queued; irq flags "all sent".
// Optional build macro UART_PARITY_EN: adds an even-parity bit after the
// data bits (11-bit frames) and reports the last popped byte's parity in
// status[4], moving the count field up by one bit.
module uart_tx_fifo #(
    parameter int CLK_DIV = 434,
    parameter int FIFO_AW = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_we,
    input  logic [7:0]  wr_data,
    input  logic        clr_ovf,
    output logic        txd,
    output logic [31:0] status,
    output logic        irq
);

    localparam int                DEPTH       = 1 << FIFO_AW;
    localparam int                BAUD_W      = $clog2(CLK_DIV);
    localparam logic [FIFO_AW:0]  DEPTH_C     = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0]  CNT_ZERO    = {(FIFO_AW+1){1'b0}};
    localparam logic [FIFO_AW:0]  CNT_ONE     = (FIFO_AW+1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ZERO   = {FIFO_AW{1'b0}};
    localparam logic [FIFO_AW-1:0] PTR_ONE    = FIFO_AW'(1);
    localparam logic [BAUD_W-1:0] BAUD_ZERO   = {BAUD_W{1'b0}};
    localparam logic [BAUD_W-1:0] BAUD_ONE    = BAUD_W'(1);
    localparam logic [BAUD_W-1:0] BAUD_LAST   = BAUD_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Even parity of one data byte.
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

    logic [7:0]         mem_r [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_r;
    logic [FIFO_AW-1:0] rd_ptr_r;
    logic [FIFO_AW:0]   count_r;
    logic [FIFO_AW:0]   count_nxt_s;
    logic               ovf_r;
    logic               ovf_nxt_s;
    state_t             state_r;
    state_t             state_nxt_s;
    logic [BAUD_W-1:0]  baud_r;
    logic [BAUD_W-1:0]  baud_nxt_s;
    logic [7:0]         shift_r;
    logic [7:0]         shift_nxt_s;
    logic [2:0]         bit_idx_r;
    logic [2:0]         bit_idx_nxt_s;
    logic               txd_r;
    logic               txd_nxt_s;
    logic               par_r;
    logic               par_nxt_s;
    logic               pop_s;
    logic               push_s;
    logic               bit_end_s;
    logic               have_data_s;
    logic [7:0]         head_s;
    logic [31:0]        status_s;

    assign bit_end_s   = (baud_r == BAUD_LAST);
    assign have_data_s = (count_r != CNT_ZERO);
    assign head_s      = mem_r[rd_ptr_r];
    // A full FIFO still accepts a write when the same edge pops a byte.
    assign push_s      = uart_we && ((count_r != DEPTH_C) || pop_s);

    // Occupancy and overflow flag next-state; an overflow beats a clear.
    always_comb begin
        count_nxt_s = count_r;
        ovf_nxt_s   = ovf_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
        if (uart_we && !push_s) begin
            ovf_nxt_s = 1'b1;
        end else if (clr_ovf) begin
            ovf_nxt_s = 1'b0;
        end else begin
            ovf_nxt_s = ovf_r;
        end
    end

    // FIFO storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // FIFO pointers, occupancy and overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
            ovf_r    <= 1'b0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            count_r <= count_nxt_s;
            ovf_r   <= ovf_nxt_s;
        end
    end

    // Transmit FSM: next state, baud timing, shifter and the next txd level.
    always_comb begin
        state_nxt_s   = state_r;
        baud_nxt_s    = baud_r + BAUD_ONE;
        shift_nxt_s   = shift_r;
        bit_idx_nxt_s = bit_idx_r;
        txd_nxt_s     = txd_r;
        par_nxt_s     = par_r;
        pop_s         = 1'b0;
        case (state_r)
            ST_IDLE: begin
                baud_nxt_s = BAUD_ZERO;
                if (have_data_s) begin
                    pop_s       = 1'b1;
                    shift_nxt_s = head_s;
                    par_nxt_s   = even_parity(head_s);
                    txd_nxt_s   = 1'b0;
                    state_nxt_s = ST_START;
                end else begin
                    txd_nxt_s   = 1'b1;
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    baud_nxt_s    = BAUD_ZERO;
                    txd_nxt_s     = shift_r[0];
                    bit_idx_nxt_s = 3'd0;
                    state_nxt_s   = ST_DATA;
                end else begin
                    txd_nxt_s = 1'b0;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    baud_nxt_s = BAUD_ZERO;
                    if (bit_idx_r == 3'd7) begin
`ifdef UART_PARITY_EN
                        txd_nxt_s   = par_r;
                        state_nxt_s = ST_PARITY;
`else
                        txd_nxt_s   = 1'b1;
                        state_nxt_s = ST_STOP;
`endif
                    end else begin
                        shift_nxt_s   = {1'b0, shift_r[7:1]};
                        txd_nxt_s     = shift_r[1];
                        bit_idx_nxt_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    txd_nxt_s = txd_r;
                end
            end
`ifdef UART_PARITY_EN
            ST_PARITY: begin
                if (bit_end_s) begin
                    baud_nxt_s  = BAUD_ZERO;
                    txd_nxt_s   = 1'b1;
                    state_nxt_s = ST_STOP;
                end else begin
                    txd_nxt_s = par_r;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end_s) begin
                    baud_nxt_s = BAUD_ZERO;
                    // Chain straight into the next start bit when data waits.
                    if (have_data_s) begin
                        pop_s       = 1'b1;
                        shift_nxt_s = head_s;
                        par_nxt_s   = even_parity(head_s);
                        txd_nxt_s   = 1'b0;
                        state_nxt_s = ST_START;
                    end else begin
                        txd_nxt_s   = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    txd_nxt_s = 1'b1;
                end
            end
            default: begin
                baud_nxt_s  = BAUD_ZERO;
                txd_nxt_s   = 1'b1;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Transmit FSM registers; txd comes straight from a flop so it cannot glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            baud_r    <= BAUD_ZERO;
            shift_r   <= 8'h00;
            bit_idx_r <= 3'd0;
            txd_r     <= 1'b1;
            par_r     <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            baud_r    <= baud_nxt_s;
            shift_r   <= shift_nxt_s;
            bit_idx_r <= bit_idx_nxt_s;
            txd_r     <= txd_nxt_s;
            par_r     <= par_nxt_s;
        end
    end

    // Status word assembled from registered state only.
    always_comb begin
        status_s    = 32'h0000_0000;
        status_s[0] = (state_r != ST_IDLE);
        status_s[1] = (count_r == DEPTH_C);
        status_s[2] = (count_r == CNT_ZERO);
        status_s[3] = ovf_r;
`ifdef UART_PARITY_EN
        status_s[4] = par_r;
        status_s[FIFO_AW+5:5] = count_r;
`else
        status_s[FIFO_AW+4:4] = count_r;
`endif
    end

    assign txd    = txd_r;
    assign status = status_s;
    assign irq    = (count_r == CNT_ZERO) && (state_r == ST_IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo (CLK_DIV=4, FIFO_AW=4, default 8N1).
// A queue-plus-frame-timeline reference model predicts txd/status/irq each
// cycle; directed checks cover the listed scenarios, then random traffic.
module tb_uart_tx_fifo;

    localparam int CLK_DIV = 4;
    localparam int FIFO_AW = 4;
    localparam int DEPTH   = 16;
    localparam int FRAME   = 10 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        uart_we = 1'b0;
    logic [7:0]  wr_data = 8'h00;
    logic        clr_ovf = 1'b0;
    logic        txd;
    logic [31:0] status;
    logic        irq;

    int total = 0;
    int bad   = 0;

    // Reference model: pending bytes, current frame byte and position in it.
    logic [7:0] m_q[$];
    bit         m_busy;
    int         m_pos;
    logic [7:0] m_byte;
    bit         m_ovf;

    uart_tx_fifo #(.CLK_DIV(CLK_DIV), .FIFO_AW(FIFO_AW)) dut (
        .clk     (clk),
        .rst     (rst),
        .uart_we (uart_we),
        .wr_data (wr_data),
        .clr_ovf (clr_ovf),
        .txd     (txd),
        .status  (status),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #20_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic void model_reset();
        m_q.delete();
        m_busy = 1'b0;
        m_pos  = 0;
        m_byte = 8'h00;
        m_ovf  = 1'b0;
    endfunction

    // One clock edge of the reference model using the inputs held this cycle.
    function automatic void model_edge();
        bit pop;
        bit acc;
        if (rst) begin
            model_reset();
            return;
        end
        pop = (m_q.size() > 0) && (!m_busy || (m_pos == FRAME - 1));
        acc = uart_we && ((m_q.size() < DEPTH) || pop);
        if (pop) begin
            m_byte = m_q.pop_front();
            m_busy = 1'b1;
            m_pos  = 0;
        end else if (m_busy) begin
            if (m_pos == FRAME - 1) m_busy = 1'b0;
            else m_pos++;
        end
        if (acc) m_q.push_back(wr_data);
        if (uart_we && !acc) m_ovf = 1'b1;
        else if (clr_ovf) m_ovf = 1'b0;
    endfunction

    // Line level: start bit, 8 data bits LSB first, stop bit.
    function automatic logic exp_txd();
        int idx;
        if (!m_busy) return 1'b1;
        idx = m_pos / CLK_DIV;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return m_byte[idx-1];
        return 1'b1;
    endfunction

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        int n;
        n = m_q.size();
        s = 32'h0;
        s[0] = m_busy;
        s[1] = (n == DEPTH);
        s[2] = (n == 0);
        s[3] = m_ovf;
        s[8:4] = 5'(n);
        return s;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("txd", {31'b0, txd}, {31'b0, exp_txd()});
        check("status", status, exp_status());
        check("irq", {31'b0, irq}, {31'b0, (!m_busy && m_q.size() == 0)});
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic wr(input logic [7:0] b);
        uart_we = 1'b1;
        wr_data = b;
        step();
        uart_we = 1'b0;
    endtask

    int   exp_bits [20] = '{0,1,1,0,0,0,1,0,1,1, 0,1,1,1,1,0,0,0,0,1};
    logic samples  [80];
    int   busy_cnt;
    int   falls;
    bit   done;

    initial begin
        model_reset();

        // 1: reset, then idle line
        run(3);
        rst = 1'b0;
        run(100);
        check("rst_status", status, 32'h0000_0004);
        check("rst_irq", {31'b0, irq}, 32'd1);

        // 2: single 0x55 frame
        wr(8'h55);
        step();
        check("t2_start", {31'b0, txd}, 32'd0);
        busy_cnt = 1;
        for (int i = 0; i < 59; i++) begin
            step();
            if (status[0]) busy_cnt++;
        end
        check("t2_busy_cycles", busy_cnt, 32'd40);
        check("t2_irq", {31'b0, irq}, 32'd1);

        // 3: two contiguous frames 0xA3, 0x0F
        wr(8'hA3);
        wr(8'h0F);
        samples[0] = txd;
        busy_cnt = status[0] ? 1 : 0;
        falls = 0;
        for (int i = 1; i < 80; i++) begin
            step();
            samples[i] = txd;
            if (status[0]) busy_cnt++;
            else falls++;
        end
        for (int k = 0; k < 20; k++) begin
            check("t3_bit", {31'b0, samples[k*CLK_DIV+2]}, 32'(exp_bits[k]));
        end
        check("t3_busy_cycles", busy_cnt, 32'd80);
        check("t3_gap", falls, 32'd0);
        step();
        check("t3_idle", {31'b0, status[0]}, 32'd0);
        run(5);

        // 4: fill while busy, overflow, clear, refill
        for (int i = 0; i <= 16; i++) wr(8'(i));
        wr(8'h11);
        check("t4_ovf", {31'b0, status[3]}, 32'd1);
        check("t4_full", {31'b0, status[1]}, 32'd1);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        check("t4_clr", {31'b0, status[3]}, 32'd0);
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            if (m_q.size() < DEPTH) done = 1'b1;
            else step();
        end
        check("t4_wait_space", {31'b0, done}, 32'd1);
        wr(8'h22);
        check("t4_refill_cnt", {27'b0, status[8:4]}, 32'd16);
        check("t4_refill_ovf", {31'b0, status[3]}, 32'd0);

        // 6: full FIFO, write on the STOP->START pop edge
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            if (m_busy && m_pos == FRAME - 1) done = 1'b1;
            else step();
        end
        check("t6_wait_edge", {31'b0, done}, 32'd1);
        wr(8'h33);
        check("t6_cnt", {27'b0, status[8:4]}, 32'd16);
        check("t6_ovf", {31'b0, status[3]}, 32'd0);
        check("t6_start", {31'b0, txd}, 32'd0);

        // random traffic, heavy then light
        for (int i = 0; i < 3000; i++) begin
            uart_we = ($urandom_range(0, (i < 1500) ? 3 : 40) == 0);
            wr_data = 8'($urandom());
            clr_ovf = ($urandom_range(0, 20) == 0);
            step();
        end
        uart_we = 1'b0;
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            if (!m_busy && m_q.size() == 0) done = 1'b1;
            else step();
        end
        check("drain", {31'b0, done}, 32'd1);
        run(3);

        // 5: reset during data bit 3 of a 0x00 frame
        wr(8'h00);
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            if (m_busy && m_pos == 4 * CLK_DIV + 1) done = 1'b1;
            else step();
        end
        check("t5_wait_bit3", {31'b0, done}, 32'd1);
        check("t5_low", {31'b0, txd}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("t5_async_txd", {31'b0, txd}, 32'd1);
        check("t5_async_status", status, 32'h0000_0004);
        model_reset();
        run(2);
        #2;
        rst = 1'b0;
        run(100);
        check("t5_after_status", status, 32'h0000_0004);
        check("t5_after_txd", {31'b0, txd}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
